cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Execution datapath driven by the CPU controller: it consumes the controller's per-instruction control word (DA/AA/BA/FS/MB/resultSource/RW/MW/EOE) and returns the A and D operand buses the program counter uses for jumps and branches. It holds a 16×16 register file, an 8-function ALU, a 64×16 data memory and a status-flag register, and commits all architectural state on the rising clock edge. It is the responder side of the controller's control-word interface.

## Interface
- busSize, 16, datapath word width
- addressWidth, 4, register address width (16 registers)
- fsWidth, 3, ALU function-select width
- memAddrWidth, 6, data memory address width (64 words)
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- DA  input  addressWidth  destination register address
- AA  input  addressWidth  A-operand register address
- BA  input  addressWidth  B-operand register address / 4-bit constant
- FS  input  fsWidth  ALU function select
- MB  input  1  0: B operand = R[BA]; 1: B operand = zero-extended BA
- resultSource  input  2  write-back source select
- RW  input  1  register write enable
- MW  input  1  data memory write enable
- EOE  input  1  end-of-execution; halts the datapath
- A  output  busSize  R[AA] (combinational)
- D  output  busSize  R[BA] (combinational, before the MB mux)
- flags  output  4  registered {Z, N, C, V}
- halted  output  1  sticky halt indicator

## Operation
- Register file: 16 registers; R0 always reads 0, writes to R0 are discarded. Two asynchronous read ports (AA, BA), one synchronous write port (DA).
- ALU on operands A and Bsel (Bsel = MB ? {12'b0, BA} : R[BA]). FS: 000 ADD, 001 SUB (A−Bsel), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by Bsel[3:0], 111 SHR (logical) A by Bsel[3:0]. Results are truncated to 16 bits.
- C: carry-out for ADD; no-borrow (A ≥ Bsel unsigned) for SUB; last bit shifted out for SHL/SHR; 0 otherwise. V: signed overflow for ADD/SUB; 0 otherwise. Z: result == 0. N: result[15].
- Write-back source, resultSource: 00 ALU result; 01 dmem[A[5:0]]; 10 Bsel (move/load-immediate); 11 zero-extended {12'b0, flags}.
- On a clock edge with RW=1: R[DA] ← write-back value. If resultSource=00, flags ← ALU flags; otherwise flags hold.
- On a clock edge with MW=1: dmem[A[5:0]] ← R[BA] (always the register value, independent of MB). A[15:6] is ignored.
- Data memory read is asynchronous.
- EOE: when EOE=1 at a clock edge, halted ← 1 and that edge performs no register, memory or flag update. While halted=1, RW and MW are ignored. halted clears only on reset.

## Timing
- Reset (synchronous): all registers, all 64 dmem words, flags and halted are cleared to 0 on the edge where reset=1. After that edge A=D=0 for every address.
- reset has priority over EOE, RW and MW in the same cycle.
- Zero-latency reads. The A, D and ALU outputs reflect the current inputs combinationally. A write becomes visible on the reads in the cycle after the edge.
- Same-cycle read/write of the same register or memory word returns the old value. There is no bypass.
- RW and MW both high in one cycle: both commit on that edge. A load (resultSource=01) combined with MW to the same address writes back the old memory value.
- Address arithmetic wraps: A[5:0] selects the word, so A=16'h0041 addresses word 1.

## Structure
- Shared package cpu_pkg holds busSize, addressWidth, fsWidth, memAddrWidth, the FS encodings, the resultSource encodings and the flag bit positions. The controller uses the same package.
- One sub-module, cpu_alu: purely combinational, with inputs A, Bsel and FS and outputs result and {Z,N,C,V}.
- The register file and data memory stay inline in cpu_datapath.

## Test plan
- Load-immediate and add: R1←7 (MB=1, resultSource=10, BA=7), R2←9, then ADD R3=R1+R2 → next cycle A(AA=3)=16'h0010, flags Z=0 N=0 C=0 V=0.
- Overflow and borrow: R1=16'h7FFF, R2=1 via SHL/ADD sequence, ADD → R3=16'h8000, N=1, V=1. SUB 0−1 → 16'hFFFF, C=0, N=1.
- Memory: MW with R[AA]=16'h0045 and R[BA]=16'hBEEF, then a load with A=16'h0005 (resultSource=01) into R4 → R4=16'hBEEF. In the same cycle as the write, the read returns the old value 0.
- R0 and flag hold: RW into DA=0 with ALU result 5 → R0 still reads 0. A resultSource=10 write leaves the previously set flags unchanged.
- Halt: EOE=1 in the same cycle as RW=1 to R5 → R5 unchanged, halted=1. Subsequent RW and MW are ignored. reset → halted=0 and all registers read 0.
- Mid-run reset: reset asserted together with RW=1 and MW=1 → the register, memory and flags are all 0 after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and the execution datapath.
// Holds the bus and address widths, the ALU function-select encodings, the
// write-back source encodings and the bit positions inside the flag word.
package cpu_pkg;

  localparam int unsigned busSize      = 16;
  localparam int unsigned addressWidth = 4;
  localparam int unsigned fsWidth      = 3;
  localparam int unsigned memAddrWidth = 6;
  localparam int unsigned flagsWidth   = 4;

  // ALU function select
  typedef enum logic [fsWidth-1:0] {
    FsAdd = 3'b000,
    FsSub = 3'b001,
    FsAnd = 3'b010,
    FsOr  = 3'b011,
    FsXor = 3'b100,
    FsNot = 3'b101,
    FsShl = 3'b110,
    FsShr = 3'b111
  } fs_e;

  // Register write-back source select
  typedef enum logic [1:0] {
    SrcAlu   = 2'b00,
    SrcMem   = 2'b01,
    SrcBsel  = 2'b10,
    SrcFlags = 2'b11
  } result_src_e;

  // Flag word is {Z, N, C, V}
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic [flagsWidth-1:0] pack_flags(input logic z, input logic n,
                                                       input logic c, input logic v);
    logic [flagsWidth-1:0] f;
    f        = '0;
    f[FlagZ] = z;
    f[FlagN] = n;
    f[FlagC] = c;
    f[FlagV] = v;
    return f;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-function ALU.
// Ports:
//   i_a      A operand
//   i_bsel   B operand (register or zero-extended constant, chosen upstream)
//   i_fs     function select (fs_e encoding)
//   o_result 16-bit truncated result
//   o_flags  {Z, N, C, V} computed from this result
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [busSize-1:0]    i_a,
  input  logic [busSize-1:0]    i_bsel,
  input  logic [fsWidth-1:0]    i_fs,
  output logic [busSize-1:0]    o_result,
  output logic [flagsWidth-1:0] o_flags
);

  logic [busSize:0] w_sum;
  logic [busSize:0] w_diff;
  logic [busSize:0] w_shl;
  logic [busSize:0] w_shr;
  logic [3:0]       w_shamt;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_carry;
  logic             w_ovf;

  assign w_shamt = i_bsel[3:0];
  assign w_sum   = {1'b0, i_a} + {1'b0, i_bsel};
  // MSB of the extended difference is the borrow; C reports its inverse.
  assign w_diff  = {1'b0, i_a} - {1'b0, i_bsel};
  // The extra bit above/below the word catches the last bit shifted out;
  // a zero shift leaves it 0.
  assign w_shl   = {1'b0, i_a} << w_shamt;
  assign w_shr   = {i_a, 1'b0} >> w_shamt;

  assign w_add_ovf = (i_a[busSize-1] == i_bsel[busSize-1]) &&
                     (w_sum[busSize-1] != i_a[busSize-1]);
  assign w_sub_ovf = (i_a[busSize-1] != i_bsel[busSize-1]) &&
                     (w_diff[busSize-1] != i_a[busSize-1]);

  always_comb begin
    o_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    unique case (fs_e'(i_fs))
      FsAdd: begin
        o_result = w_sum[busSize-1:0];
        w_carry  = w_sum[busSize];
        w_ovf    = w_add_ovf;
      end
      FsSub: begin
        o_result = w_diff[busSize-1:0];
        w_carry  = ~w_diff[busSize];
        w_ovf    = w_sub_ovf;
      end
      FsAnd: o_result = i_a & i_bsel;
      FsOr:  o_result = i_a | i_bsel;
      FsXor: o_result = i_a ^ i_bsel;
      FsNot: o_result = ~i_a;
      FsShl: begin
        o_result = w_shl[busSize-1:0];
        w_carry  = w_shl[busSize];
      end
      FsShr: begin
        o_result = w_shr[busSize:1];
        w_carry  = w_shr[0];
      end
      default: o_result = '0;
    endcase
  end

  assign o_flags = pack_flags(~|o_result, o_result[busSize-1], w_carry, w_ovf);

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath: 16x16 register file, ALU, 64x16 data memory, status
// flags and a sticky halt bit. Responder to the controller's control word.
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   DA, AA, BA          destination / A-read / B-read (or constant) addresses
//   FS, MB              ALU function; B operand source (0 reg, 1 constant)
//   resultSource        write-back source (result_src_e)
//   RW, MW              register / data memory write enables
//   EOE                 end of execution, sets halted
//   A, D                combinational R[AA] and R[BA]
//   flags               registered {Z, N, C, V}
//   halted              sticky halt indicator
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addressWidth-1:0] DA,
  input  logic [addressWidth-1:0] AA,
  input  logic [addressWidth-1:0] BA,
  input  logic [fsWidth-1:0]      FS,
  input  logic                    MB,
  input  logic [1:0]              resultSource,
  input  logic                    RW,
  input  logic                    MW,
  input  logic                    EOE,
  output logic [busSize-1:0]      A,
  output logic [busSize-1:0]      D,
  output logic [flagsWidth-1:0]   flags,
  output logic                    halted
);

  localparam int unsigned NumRegs  = 2 ** addressWidth;
  localparam int unsigned NumWords = 2 ** memAddrWidth;

  logic [busSize-1:0]    r_regs [NumRegs];
  logic [busSize-1:0]    r_dmem [NumWords];
  logic [flagsWidth-1:0] r_flags;
  logic                  r_halted;

  logic [busSize-1:0]      w_bsel;
  logic [busSize-1:0]      w_alu_result;
  logic [flagsWidth-1:0]   w_alu_flags;
  logic [memAddrWidth-1:0] w_mem_addr;
  logic [busSize-1:0]      w_mem_rdata;
  logic [busSize-1:0]      w_wb_data;
  logic                    w_commit;
  logic                    w_reg_we;
  logic                    w_flag_we;
  logic                    w_mem_we;

  // R0 is never written and is cleared by reset, so it always reads 0.
  assign A = r_regs[AA];
  assign D = r_regs[BA];

  assign w_bsel = MB ? {{(busSize-addressWidth){1'b0}}, BA} : D;

  cpu_alu u_alu (
    .i_a      (A),
    .i_bsel   (w_bsel),
    .i_fs     (FS),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // Only the low address bits select a word; upper bits of A wrap.
  assign w_mem_addr  = A[memAddrWidth-1:0];
  assign w_mem_rdata = r_dmem[w_mem_addr];

  always_comb begin
    w_wb_data = '0;
    unique case (result_src_e'(resultSource))
      SrcAlu:   w_wb_data = w_alu_result;
      SrcMem:   w_wb_data = w_mem_rdata;
      SrcBsel:  w_wb_data = w_bsel;
      SrcFlags: w_wb_data = {{(busSize-flagsWidth){1'b0}}, r_flags};
      default:  w_wb_data = '0;
    endcase
  end

  // An EOE edge retires nothing; once halted, no further state changes.
  assign w_commit  = ~r_halted & ~EOE;
  assign w_reg_we  = w_commit & RW & (DA != '0);
  assign w_flag_we = w_commit & RW & (resultSource == SrcAlu);
  assign w_mem_we  = w_commit & MW;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_we) begin
      r_regs[DA] <= w_wb_data;
    end
  end

  // Stores always take the register value, never the MB constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumWords; i++) begin
        r_dmem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_dmem[w_mem_addr] <= D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_flag_we) begin
        r_flags <= w_alu_flags;
      end
      if (EOE) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign flags  = r_flags;
  assign halted = r_halted;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: a directed table of control words with hand-derived
// expectations, then random control words checked against a behavioural model.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  DA, AA, BA;
  logic [2:0]  FS;
  logic        MB;
  logic [1:0]  resultSource;
  logic        RW, MW, EOE;
  logic [15:0] A, D;
  logic [3:0]  flags;
  logic        halted;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .DA           (DA),
    .AA           (AA),
    .BA           (BA),
    .FS           (FS),
    .MB           (MB),
    .resultSource (resultSource),
    .RW           (RW),
    .MW           (MW),
    .EOE          (EOE),
    .A            (A),
    .D            (D),
    .flags        (flags),
    .halted       (halted)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  da, aa, ba;
    logic [2:0]  fs;
    logic        mb;
    logic [1:0]  src;
    logic        rw, mw, eoe;
    logic [15:0] ea, ed;
    logic [3:0]  ef;
    logic        eh;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state
  logic [15:0] m_regs [16];
  logic [15:0] m_mem  [64];
  logic [3:0]  m_flags;
  logic        m_halt;

  function automatic vec_t mk(input logic rst, input int da, input int aa, input int ba,
                              input int fs, input int mb, input int src, input int rw,
                              input int mw, input int eoe, input logic [15:0] ea,
                              input logic [15:0] ed, input logic [3:0] ef, input logic eh);
    vec_t v;
    v.rst = rst;  v.da = da[3:0];  v.aa = aa[3:0];  v.ba = ba[3:0];
    v.fs  = fs[2:0];  v.mb = mb[0];  v.src = src[1:0];
    v.rw  = rw[0];  v.mw = mw[0];  v.eoe = eoe[0];
    v.ea  = ea;  v.ed = ed;  v.ef = ef;  v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU rules from plain integer arithmetic.
  task automatic alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [2:0] fs,
                         output logic [15:0] r, output logic [3:0] f);
    int unsigned ua, ub, ur, n;
    int          sa, sb, sr;
    logic        c, v;
    ua = a;  ub = b;  n = b[3:0];
    sa = int'($signed(a));  sb = int'($signed(b));
    c = 1'b0;  v = 1'b0;  ur = 0;
    case (fs)
      3'd0: begin
        ur = ua + ub;  c = (ur > 65535);
        sr = sa + sb;  v = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        ur = ua - ub;  c = (ua >= ub);
        sr = sa - sb;  v = (sr > 32767) || (sr < -32768);
      end
      3'd2: ur = ua & ub;
      3'd3: ur = ua | ub;
      3'd4: ur = ua ^ ub;
      3'd5: ur = ~ua;
      3'd6: begin
        ur = ua << n;
        c  = (n != 0) && (((ua >> (16 - n)) & 1) == 1);
      end
      default: begin
        ur = ua >> n;
        c  = (n != 0) && (((ua >> (n - 1)) & 1) == 1);
      end
    endcase
    r = ur[15:0];
    f = {r == 16'h0, r[15], c, v};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_flags = '0;
    m_halt  = 1'b0;
  endtask

  task automatic model_edge(input vec_t v);
    logic [15:0] a, d, bsel, r, wb;
    logic [3:0]  f;
    int          addr;
    if (v.rst) begin
      model_reset();
      return;
    end
    if (m_halt) return;
    if (v.eoe) begin
      m_halt = 1'b1;
      return;
    end
    a    = m_regs[v.aa];
    d    = m_regs[v.ba];
    bsel = v.mb ? {12'h0, v.ba} : d;
    addr = a % 64;
    alu_ref(a, bsel, v.fs, r, f);
    case (v.src)
      2'd0:    wb = r;
      2'd1:    wb = m_mem[addr];
      2'd2:    wb = bsel;
      default: wb = {12'h0, m_flags};
    endcase
    if (v.rw) begin
      if (v.da != 0) m_regs[v.da] = wb;
      if (v.src == 2'd0) m_flags = f;
    end
    if (v.mw) m_mem[addr] = d;
  endtask

  // Starts and ends at a falling edge.
  task automatic step(input vec_t v, input bit use_table, input string tag);
    logic [15:0] ea, ed;
    reset = v.rst;  DA = v.da;  AA = v.aa;  BA = v.ba;  FS = v.fs;  MB = v.mb;
    resultSource = v.src;  RW = v.rw;  MW = v.mw;  EOE = v.eoe;
    #1;
    ea = use_table ? v.ea : m_regs[v.aa];
    ed = use_table ? v.ed : m_regs[v.ba];
    chk({tag, " A"}, A, ea);
    chk({tag, " D"}, D, ed);
    @(posedge clk);
    model_edge(v);
    #1;
    chk({tag, " flags"}, {12'h0, flags}, use_table ? {12'h0, v.ef} : {12'h0, m_flags});
    chk({tag, " halted"}, {15'h0, halted}, use_table ? {15'h0, v.eh} : {15'h0, m_halt});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // rst, da,aa,ba, fs,mb,src, rw,mw,eoe, A, D, flags, halted
    vecs.push_back(mk(0, 0, 5, 9,  0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'b0000, 0)); // reset state
    vecs.push_back(mk(0, 1, 0, 7,  0,1,2, 1,0,0, 16'h0000, 16'h0000, 4'b0000, 0)); // R1<-7
    vecs.push_back(mk(0, 2, 1, 9,  0,1,2, 1,0,0, 16'h0007, 16'h0000, 4'b0000, 0)); // R2<-9
    vecs.push_back(mk(0, 3, 1, 2,  0,0,0, 1,0,0, 16'h0007, 16'h0009, 4'b0000, 0)); // R3=R1+R2
    vecs.push_back(mk(0, 0, 3, 3,  0,0,0, 0,0,0, 16'h0010, 16'h0010, 4'b0000, 0));
    vecs.push_back(mk(0, 5, 0, 1,  0,1,2, 1,0,0, 16'h0000, 16'h0007, 4'b0000, 0)); // R5<-1
    vecs.push_back(mk(0, 5, 5, 15, 6,1,0, 1,0,0, 16'h0001, 16'h0000, 4'b0100, 0)); // SHL 15
    vecs.push_back(mk(0, 6, 5, 1,  1,1,0, 1,0,0, 16'h8000, 16'h0007, 4'b0011, 0)); // 8000-1
    vecs.push_back(mk(0, 7, 6, 1,  0,1,0, 1,0,0, 16'h7FFF, 16'h0007, 4'b0101, 0)); // 7FFF+1
    vecs.push_back(mk(0, 8, 0, 1,  1,1,0, 1,0,0, 16'h0000, 16'h0007, 4'b0100, 0)); // 0-1
    vecs.push_back(mk(0, 0, 7, 8,  0,0,0, 0,0,0, 16'h8000, 16'hFFFF, 4'b0100, 0));
    vecs.push_back(mk(0, 9, 0, 11, 0,1,2, 1,0,0, 16'h0000, 16'h0000, 4'b0100, 0)); // build BEEF
    vecs.push_back(mk(0, 9, 9, 4,  6,1,0, 1,0,0, 16'h000B, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 9, 9, 14, 3,1,0, 1,0,0, 16'h00B0, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 9, 9, 4,  6,1,0, 1,0,0, 16'h00BE, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 9, 9, 14, 3,1,0, 1,0,0, 16'h0BE0, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 9, 9, 4,  6,1,0, 1,0,0, 16'h0BEE, 16'h0000, 4'b0100, 0));
    vecs.push_back(mk(0, 9, 9, 15, 3,1,0, 1,0,0, 16'hBEE0, 16'h0000, 4'b0100, 0));
    vecs.push_back(mk(0, 10, 0, 4, 0,1,2, 1,0,0, 16'h0000, 16'h0000, 4'b0100, 0)); // build 45
    vecs.push_back(mk(0, 10,10, 4, 6,1,0, 1,0,0, 16'h0004, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 10,10, 5, 3,1,0, 1,0,0, 16'h0040, 16'h8000, 4'b0000, 0));
    vecs.push_back(mk(0, 11,10, 9, 0,0,1, 1,1,0, 16'h0045, 16'hBEEF, 4'b0000, 0)); // store+load
    vecs.push_back(mk(0, 12,11, 5, 0,1,2, 1,0,0, 16'h0000, 16'h8000, 4'b0000, 0)); // R11 old=0
    vecs.push_back(mk(0, 4, 12, 0, 0,0,1, 1,0,0, 16'h0005, 16'h0000, 4'b0000, 0)); // R4=mem[5]
    vecs.push_back(mk(0, 0, 4, 0,  0,0,0, 0,0,0, 16'hBEEF, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 13,10, 0, 0,0,1, 1,0,0, 16'h0045, 16'h0000, 4'b0000, 0)); // wrap load
    vecs.push_back(mk(0, 0, 13, 0, 0,0,0, 0,0,0, 16'hBEEF, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 12, 0, 0,0,0, 1,0,0, 16'h0005, 16'h0000, 4'b0000, 0)); // R0<-5
    vecs.push_back(mk(0, 13, 0, 1, 1,1,0, 1,0,0, 16'h0000, 16'h0007, 4'b0100, 0));
    vecs.push_back(mk(0, 14, 0, 3, 0,1,2, 1,0,0, 16'h0000, 16'h0010, 4'b0100, 0)); // flags hold
    vecs.push_back(mk(0, 5, 5, 2,  0,1,2, 1,0,1, 16'h8000, 16'h0009, 4'b0100, 1)); // EOE+RW
    vecs.push_back(mk(0, 5, 5, 2,  0,1,2, 1,1,0, 16'h8000, 16'h0009, 4'b0100, 1)); // ignored
    vecs.push_back(mk(0, 0, 5, 14, 0,0,0, 0,0,0, 16'h8000, 16'h0003, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 0, 0,  0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'b0000, 0)); // reset
    vecs.push_back(mk(0, 0, 1, 9,  0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 0, 7,  0,1,2, 1,0,0, 16'h0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 2, 0, 1,  1,0,0, 1,0,0, 16'h0000, 16'h0007, 4'b0100, 0));
    vecs.push_back(mk(1, 3, 0, 1,  0,1,2, 1,1,0, 16'h0000, 16'h0007, 4'b0000, 0)); // rst+RW+MW
    vecs.push_back(mk(0, 6, 0, 1,  0,0,1, 1,0,0, 16'h0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 6, 3,  0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'b0000, 0));

    reset = 1'b1;  DA = '0;  AA = '0;  BA = '0;  FS = '0;  MB = 1'b0;
    resultSource = '0;  RW = 1'b0;  MW = 1'b0;  EOE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    foreach (vecs[i]) begin
      step(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0);
    step(v, 1'b0, "rnd_reset");
    for (int n = 0; n < 600; n++) begin
      v.rst = ($urandom_range(99) == 0);
      v.da  = 4'($urandom_range(15));
      v.aa  = 4'($urandom_range(15));
      v.ba  = 4'($urandom_range(15));
      v.fs  = 3'($urandom_range(7));
      v.mb  = 1'($urandom_range(1));
      v.src = 2'($urandom_range(3));
      v.rw  = ($urandom_range(3) != 0);
      v.mw  = ($urandom_range(2) == 0);
      v.eoe = ($urandom_range(79) == 0);
      step(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
